null_src_sink_gen_core: RTL and testbench

- Parametrised successor to the null source/sink datapath: one AXI-Stream traffic source and one AXI-Stream sink/checker, with line and packet counters.
- Adds selectable data patterns, a sink-side pattern checker with an error counter, programmable inter-line throttle, and a bounded burst length with guaranteed EOB on the final packet.
- Sits behind the block's register interface and NoC shell. CHDR header and framing are handled upstream; this core sees payload lines only.

---
 rtl/null_src_sink_gen_core.sv | 262 ++++++++++++++++++++++++++
 tb/tb_null_src_sink_gen_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/null_src_sink_gen_core.sv
// Pattern-generating AXI-Stream source and checking sink with line, packet and error statistics.
// The source runs bounded or unbounded bursts and always ends a run on a full packet carrying EOB.
module null_src_sink_gen_core #(
    parameter int ITEM_W = 32,
    parameter int NIPC   = 2,
    parameter int LPP_W  = 16,
    parameter int GAP_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   src_en,
    input  logic [1:0]             src_mode,
    input  logic [ITEM_W-1:0]      src_const,
    input  logic [LPP_W-1:0]       src_lpp_m1,
    input  logic [GAP_W-1:0]       src_gap,
    input  logic [CNT_W-1:0]       src_num_pkts,
    input  logic                   chk_en,
    input  logic                   clear,
    output logic [ITEM_W*NIPC-1:0] m_tdata,
    output logic                   m_tlast,
    output logic                   m_teob,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    input  logic [ITEM_W*NIPC-1:0] s_tdata,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic                   src_busy,
    output logic [CNT_W-1:0]       src_line_cnt,
    output logic [CNT_W-1:0]       src_pkt_cnt,
    output logic [CNT_W-1:0]       snk_line_cnt,
    output logic [CNT_W-1:0]       snk_pkt_cnt,
    output logic [CNT_W-1:0]       snk_err_cnt
);
    localparam int          LINE_W    = ITEM_W * NIPC;
    localparam int          HALF_W    = ITEM_W / 2;
    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [LINE_W-1:0] pattern(input logic [1:0] mode, input logic [HALF_W-1:0] idx,
                                                  input logic [31:0] lfsr, input logic [ITEM_W-1:0] cnst);
        logic [ITEM_W-1:0] item;
        case (mode)
            2'd1:    item = lfsr[ITEM_W-1:0];
            2'd2:    item = cnst;
            default: item = {~idx, idx};
        endcase
        return {NIPC{item}};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t              state;
    logic [1:0]          cfg_mode;
    logic [ITEM_W-1:0]   cfg_const;
    logic [LPP_W-1:0]    cfg_lpp_m1;
    logic [GAP_W-1:0]    cfg_gap;
    logic [CNT_W-1:0]    cfg_num_pkts;
    logic [HALF_W-1:0]   src_idx;
    logic [31:0]         src_lfsr;
    logic [LPP_W-1:0]    line_idx;
    logic [CNT_W-1:0]    pkt_idx;
    logic [GAP_W-1:0]    gap_cnt;
    logic                stop_pend;
    logic                abort_pend;
    logic [HALF_W-1:0]   snk_idx;
    logic [31:0]         snk_lfsr;
    logic [LINE_W-1:0]   snk_exp;
    logic                beat_acc;
    logic                snk_acc;

    logic [1:0]          ld_mode;
    logic [ITEM_W-1:0]   ld_const;
    logic [LPP_W-1:0]    ld_lpp;
    logic [CNT_W-1:0]    ld_num;
    logic [HALF_W-1:0]   ld_idx;
    logic [31:0]         ld_lfsr;
    logic [LPP_W-1:0]    ld_line;
    logic [CNT_W-1:0]    ld_pkt;
    logic                ld_last;
    logic                ld_eob;
    logic                stop_now;
    logic [LINE_W-1:0]   ld_data;

    assign beat_acc = m_tvalid & m_tready;
    assign snk_acc  = s_tvalid & s_tready;
    assign src_busy = (state != IDLE);
    assign snk_exp  = pattern(src_mode, snk_idx, snk_lfsr, src_const);

    // Next line to present: live config out of IDLE, sampled config afterwards; advanced state on acceptance.
    always_comb begin
        ld_mode  = cfg_mode;
        ld_const = cfg_const;
        ld_lpp   = cfg_lpp_m1;
        ld_num   = cfg_num_pkts;
        ld_idx   = src_idx;
        ld_lfsr  = src_lfsr;
        ld_line  = line_idx;
        ld_pkt   = pkt_idx;
        stop_now = 1'b0;
        if (state == IDLE) begin
            ld_mode  = src_mode;
            ld_const = src_const;
            ld_lpp   = src_lpp_m1;
            ld_num   = src_num_pkts;
        end else begin
            stop_now = stop_pend | ~src_en;
        end
        if (state == RUN && beat_acc) begin
            ld_idx  = src_idx + HALF_W'(1);
            ld_lfsr = lfsr_step(src_lfsr);
            ld_line = m_tlast ? '0 : line_idx + LPP_W'(1);
            ld_pkt  = m_tlast ? pkt_idx + CNT_W'(1) : pkt_idx;
        end
        ld_last = (ld_line == ld_lpp);
        ld_eob  = ld_last & (stop_now | ((ld_num != '0) && (ld_pkt == ld_num - CNT_W'(1))));
        ld_data = pattern(ld_mode, ld_idx, ld_lfsr, ld_const);
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && src_en && !clear) begin
            cfg_mode     <= src_mode;
            cfg_const    <= src_const;
            cfg_lpp_m1   <= src_lpp_m1;
            cfg_gap      <= src_gap;
            cfg_num_pkts <= src_num_pkts;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src_idx    <= '0;
            src_lfsr   <= LFSR_SEED;
            line_idx   <= '0;
            pkt_idx    <= '0;
            gap_cnt    <= '0;
            stop_pend  <= 1'b0;
            abort_pend <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
            m_teob     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stop_pend  <= 1'b0;
                    abort_pend <= 1'b0;
                    if (src_en && !clear) begin
                        state    <= RUN;
                        m_tvalid <= 1'b1;
                        m_tdata  <= ld_data;
                        m_tlast  <= ld_last;
                        m_teob   <= ld_eob;
                    end
                end
                RUN: begin
                    if (!src_en) stop_pend <= 1'b1;
                    if (clear) abort_pend <= 1'b1;
                    if (beat_acc) begin
                        // An aborted run must not consume a pattern step after the clear.
                        if (!abort_pend) begin
                            src_idx  <= ld_idx;
                            src_lfsr <= ld_lfsr;
                        end
                        line_idx <= ld_line;
                        pkt_idx  <= ld_pkt;
                        if (clear || abort_pend || m_teob) begin
                            state      <= IDLE;
                            m_tvalid   <= 1'b0;
                            m_tlast    <= 1'b0;
                            m_teob     <= 1'b0;
                            stop_pend  <= 1'b0;
                            abort_pend <= 1'b0;
                            line_idx   <= '0;
                            pkt_idx    <= '0;
                        end else if (cfg_gap != '0) begin
                            state    <= GAP;
                            gap_cnt  <= cfg_gap;
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            m_teob   <= 1'b0;
                        end else begin
                            m_tvalid <= 1'b1;
                            m_tdata  <= ld_data;
                            m_tlast  <= ld_last;
                            m_teob   <= ld_eob;
                        end
                    end
                end
                GAP: begin
                    if (!src_en) stop_pend <= 1'b1;
                    if (clear) begin
                        state      <= IDLE;
                        stop_pend  <= 1'b0;
                        abort_pend <= 1'b0;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        state    <= RUN;
                        m_tvalid <= 1'b1;
                        m_tdata  <= ld_data;
                        m_tlast  <= ld_last;
                        m_teob   <= ld_eob;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (clear) begin
                src_idx  <= '0;
                src_lfsr <= LFSR_SEED;
                line_idx <= '0;
                pkt_idx  <= '0;
            end
        end
    end

    // Statistics and the sink-side expected-pattern generator; clear outranks any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_tready     <= 1'b0;
            src_line_cnt <= '0;
            src_pkt_cnt  <= '0;
            snk_line_cnt <= '0;
            snk_pkt_cnt  <= '0;
            snk_err_cnt  <= '0;
            snk_idx      <= '0;
            snk_lfsr     <= LFSR_SEED;
        end else begin
            s_tready <= 1'b1;
            if (clear) begin
                src_line_cnt <= '0;
                src_pkt_cnt  <= '0;
                snk_line_cnt <= '0;
                snk_pkt_cnt  <= '0;
                snk_err_cnt  <= '0;
                snk_idx      <= '0;
                snk_lfsr     <= LFSR_SEED;
            end else begin
                if (beat_acc) src_line_cnt <= sat_inc(src_line_cnt);
                if (beat_acc && m_tlast) src_pkt_cnt <= sat_inc(src_pkt_cnt);
                if (snk_acc) begin
                    snk_line_cnt <= sat_inc(snk_line_cnt);
                    snk_idx      <= snk_idx + HALF_W'(1);
                    snk_lfsr     <= lfsr_step(snk_lfsr);
                    if (s_tlast) snk_pkt_cnt <= sat_inc(snk_pkt_cnt);
                    if (chk_en && (s_tdata != snk_exp)) snk_err_cnt <= sat_inc(snk_err_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_null_src_sink_gen_core.sv
// Directed-sequence bench with randomized backpressure, checked against a line-level pattern model.
module tb_null_src_sink_gen_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        src_en = 1'b0;
    logic [1:0]  src_mode = 2'd0;
    logic [31:0] src_const = 32'h0;
    logic [15:0] src_lpp_m1 = 16'd0;
    logic [7:0]  src_gap = 8'd0;
    logic [31:0] src_num_pkts = 32'd0;
    logic        chk_en = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] m_tdata;
    logic        m_tlast, m_teob, m_tvalid;
    logic        m_tready = 1'b0;
    logic [63:0] s_tdata;
    logic        s_tlast, s_tvalid, s_tready;
    logic        src_busy;
    logic [31:0] src_line_cnt, src_pkt_cnt, snk_line_cnt, snk_pkt_cnt, snk_err_cnt;

    logic        loop_en = 1'b0;
    logic [63:0] corrupt = 64'h0;

    // Model state: global line index and LFSR since last clear/reset, expected statistics.
    int unsigned g_idx;
    logic [31:0] g_lfsr;
    int          m_lines, m_pkts, k_lines, k_pkts, k_err;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign s_tdata  = m_tdata ^ corrupt;
    assign s_tlast  = m_tlast;
    assign s_tvalid = loop_en & m_tvalid & m_tready;

    null_src_sink_gen_core #(.ITEM_W(32), .NIPC(2), .LPP_W(16), .GAP_W(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .src_en(src_en), .src_mode(src_mode), .src_const(src_const),
        .src_lpp_m1(src_lpp_m1), .src_gap(src_gap), .src_num_pkts(src_num_pkts), .chk_en(chk_en),
        .clear(clear), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_teob(m_teob), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .src_busy(src_busy), .src_line_cnt(src_line_cnt),
        .src_pkt_cnt(src_pkt_cnt), .snk_line_cnt(snk_line_cnt), .snk_pkt_cnt(snk_pkt_cnt),
        .snk_err_cnt(snk_err_cnt)
    );

    // Polynomial x^32+x^22+x^2+x+1 in right-shifting Galois form.
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        logic [31:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
        return n;
    endfunction

    function automatic logic [31:0] exp_item(input logic [1:0] md, input int unsigned k,
                                             input logic [31:0] l, input logic [31:0] c);
        case (md)
            2'd1:    return l;
            2'd2:    return c;
            default: return {~k[15:0], k[15:0]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        g_idx = 0; g_lfsr = 32'hFFFF_FFFF;
        m_lines = 0; m_pkts = 0; k_lines = 0; k_pkts = 0; k_err = 0;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_src_lines"}, src_line_cnt, m_lines);
        chk({tag, "_src_pkts"},  src_pkt_cnt,  m_pkts);
        chk({tag, "_snk_lines"}, snk_line_cnt, k_lines);
        chk({tag, "_snk_pkts"},  snk_pkt_cnt,  k_pkts);
        chk({tag, "_snk_err"},   snk_err_cnt,  k_err);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        chk_cnts("clear");
    endtask

    // One run: final_pkt is the 0-based packet expected to carry EOB; stop/clear/corrupt triggers use -1 for none.
    task automatic run(input logic [1:0] mode, input int lpp, input int gap, input int num, input bit rnd,
                       input int final_pkt, input int stop_pkt, input int stop_line, input int clr_pkt,
                       input int corrupt_ln);
        int          pos = 0, pkt = 0, lines = 0, gap_left = 0;
        bit          done = 0, started = 0, stop_now = 0, clr_now, fin;
        logic [31:0] it;
        src_mode = mode; src_lpp_m1 = 16'(lpp); src_gap = 8'(gap); src_num_pkts = 32'(num);
        src_en = 1'b1;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            clr_now = 0;
            if (m_tvalid) started = 1;
            if (started) begin
                if (gap_left > 0) begin
                    chk("gap_idle", m_tvalid, 0);
                    gap_left--;
                end else begin
                    chk("valid_run", m_tvalid, 1);
                end
            end
            if (m_tvalid && m_tready) begin
                it  = exp_item(mode, g_idx, g_lfsr, src_const);
                fin = (pos == lpp) && (pkt == final_pkt);
                chk("data", m_tdata, {it, it});
                chk("tlast", m_tlast, pos == lpp);
                chk("teob", m_teob, fin);
                if (pkt == clr_pkt && pos == lpp) begin clear = 1'b1; clr_now = 1; end
                if (pkt == stop_pkt && pos == stop_line) stop_now = 1;
                if (lines == corrupt_ln) begin
                    corrupt = 64'h1;
                    if (loop_en && chk_en) k_err++;
                end
                g_idx++; g_lfsr = lfsr_next(g_lfsr); lines++; m_lines++;
                if (loop_en) k_lines++;
                if (pos == lpp) begin
                    m_pkts++;
                    if (loop_en) k_pkts++;
                    pos = 0; pkt++;
                end else begin
                    pos++;
                end
                gap_left = gap;
                done = fin || clr_now;
            end
            @(posedge clk); #1;
            clear = 1'b0; corrupt = 64'h0;
            if (stop_now || done) src_en = 1'b0;
            if (clr_now) begin
                model_reset();
                chk("clr_busy", src_busy, 0);
                chk("clr_valid", m_tvalid, 0);
                chk_cnts("clr");
            end
        end
        chk("run_done", done, 1);
        @(posedge clk); #1;
        chk("idle_busy", src_busy, 0);
        chk("idle_valid", m_tvalid, 0);
        chk_cnts("post_run");
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_tready", s_tready, 0);
        chk("rst_valid", m_tvalid, 0);
        chk("rst_busy", src_busy, 0);
        chk_cnts("rst");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_tready", s_tready, 1);

        // Bounded counter burst, then with throttle and random backpressure.
        run(2'd0, 100, 0, 5, 0, 4, -1, -1, -1, -1);
        chk("t1_lines", src_line_cnt, 505);
        chk("t1_pkts", src_pkt_cnt, 5);
        run(2'd0, 100, 3, 5, 1, 4, -1, -1, -1, -1);

        // Unbounded: stop mid packet 2, then stop right after packet 2 completes.
        run(2'd0, 20, 0, 0, 1, 1, 1, 10, -1, -1);
        run(2'd0, 20, 0, 0, 1, 2, 1, 20, -1, -1);

        // Loopback through the checker.
        do_clear();
        loop_en = 1'b1; chk_en = 1'b1;
        run(2'd1, 7, 1, 20, 1, 19, -1, -1, -1, -1);
        chk("lfsr_snk_pkts", snk_pkt_cnt, 20);
        chk("lfsr_snk_err", snk_err_cnt, 0);
        run(2'd1, 7, 1, 2, 1, 1, -1, -1, -1, 5);
        chk("corrupt_err", snk_err_cnt, 1);
        src_const = $urandom;
        run(2'd2, 3, 0, 2, 1, 1, -1, -1, -1, -1);
        run(2'd3, 3, 2, 1, 1, 0, -1, -1, -1, -1);
        loop_en = 1'b0; chk_en = 1'b0;

        // Clear coincident with a tlast, then a fresh run restarts at index 0.
        run(2'd0, 7, 0, 0, 0, -1, -1, -1, 1, -1);
        run(2'd0, 3, 0, 1, 0, 0, -1, -1, -1, -1);

        // Asynchronous reset mid packet.
        src_mode = 2'd0; src_lpp_m1 = 16'd15; src_gap = 8'd0; src_num_pkts = 32'd0;
        m_tready = 1'b1; src_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_rst_busy", src_busy, 1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", m_tvalid, 0);
        chk("arst_data", m_tdata, 0);
        chk("arst_tlast", m_tlast, 0);
        chk("arst_teob", m_teob, 0);
        chk("arst_tready", s_tready, 0);
        chk("arst_busy", src_busy, 0);
        chk_cnts("arst");
        src_en = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        chk("arst_rel_tready0", s_tready, 0);
        @(posedge clk); #1;
        chk("arst_rel_tready1", s_tready, 1);
        chk("arst_rel_busy", src_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
